// File: rtl/video_timing_generator_if.sv
// Purpose : raster timing bundle from the timing generator to the pixel pipeline and VGA pins.
// Latency : no logic here; every signal comes straight from a generator register.
// Backpressure: none; consumers sample on the pixel clock-enable and cannot stall the raster.
// Ports   : o_hpos/o_vpos position, o_hsync/o_vsync pins, o_hblank/o_vblank/o_visible/o_border
//           area flags, o_line_start/o_frame_start strobes, o_frame_count frame number.
interface video_timing_generator_if #(
  parameter int COUNT_W = 10,
  parameter int FRAME_W = 8
);
  logic [COUNT_W-1:0] o_hpos;
  logic [COUNT_W-1:0] o_vpos;
  logic               o_hsync;
  logic               o_vsync;
  logic               o_hblank;
  logic               o_vblank;
  logic               o_visible;
  logic               o_border;
  logic               o_line_start;
  logic               o_frame_start;
  logic [FRAME_W-1:0] o_frame_count;

  modport master (
    output o_hpos, o_vpos, o_hsync, o_vsync, o_hblank, o_vblank,
           o_visible, o_border, o_line_start, o_frame_start, o_frame_count
  );

  modport slave (
    input  o_hpos, o_vpos, o_hsync, o_vsync, o_hblank, o_vblank,
           o_visible, o_border, o_line_start, o_frame_start, o_frame_count
  );
endinterface

// File: rtl/video_timing_generator.sv
// Purpose : parametrised raster timing generator (sync, blanking, border, position, strobes, frame count).
// Latency : zero between position and flags; all outputs come from one register stage loaded together.
// Backpressure: none; i_ce paces the raster, and strobes clear on the next i_clk even when i_ce is low.
// Ports   : i_clk clock, i_rst_n synchronous active-low reset, i_ce pixel enable,
//           vid (master modport) carries every timing output.
module video_timing_generator #(
  parameter int H_VISIBLE       = 640,
  parameter int H_RIGHT_BORDER  = 8,
  parameter int H_FRONT_PORCH   = 8,
  parameter int H_SYNC_TIME     = 96,
  parameter int H_BACK_PORCH    = 40,
  parameter int H_LEFT_BORDER   = 8,
  parameter int V_VISIBLE       = 480,
  parameter int V_BOTTOM_BORDER = 8,
  parameter int V_FRONT_PORCH   = 2,
  parameter int V_SYNC_TIME     = 2,
  parameter int V_BACK_PORCH    = 25,
  parameter int V_TOP_BORDER    = 8,
  parameter bit H_SYNC_POL      = 1'b0,
  parameter bit V_SYNC_POL      = 1'b0,
  parameter int COUNT_W         = 10,
  parameter int FRAME_W         = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_ce,
  video_timing_generator_if.master  vid
);

  localparam int H_BLANK_START = H_VISIBLE + H_RIGHT_BORDER;
  localparam int H_SYNC_START  = H_BLANK_START + H_FRONT_PORCH;
  localparam int H_SYNC_END    = H_SYNC_START + H_SYNC_TIME;
  localparam int H_BORDER_L    = H_SYNC_END + H_BACK_PORCH;
  localparam int H_TOTAL       = H_BORDER_L + H_LEFT_BORDER;

  localparam int V_BLANK_START = V_VISIBLE + V_BOTTOM_BORDER;
  localparam int V_SYNC_START  = V_BLANK_START + V_FRONT_PORCH;
  localparam int V_SYNC_END    = V_SYNC_START + V_SYNC_TIME;
  localparam int V_BORDER_T    = V_SYNC_END + V_BACK_PORCH;
  localparam int V_TOTAL       = V_BORDER_T + V_TOP_BORDER;

  localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_TOTAL - 1);

  // The reset position is the last pixel of the frame, which lies in the
  // left border column of the top border line only if both are non-empty.
  localparam bit BORDER_RST = (H_LEFT_BORDER > 0) && (V_TOP_BORDER > 0);

  logic [COUNT_W-1:0] hpos_q, hpos_d;
  logic [COUNT_W-1:0] vpos_q, vpos_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic hblank_q, hblank_d;
  logic vblank_q, vblank_d;
  logic visible_q, visible_d;
  logic border_q, border_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  logic h_wrap, v_wrap;
  logic h_sync_act, v_sync_act;
  int   hx, vy;

  always_comb begin
    h_wrap = (hpos_q == H_LAST);
    v_wrap = (vpos_q == V_LAST);

    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (i_ce) begin
      hpos_d = h_wrap ? '0 : hpos_q + COUNT_W'(1);
      if (h_wrap) begin
        vpos_d = v_wrap ? '0 : vpos_q + COUNT_W'(1);
      end
    end

    // Strobes are recomputed every clock, so they drop after one cycle
    // regardless of i_ce.
    line_start_d  = i_ce & h_wrap;
    frame_start_d = i_ce & h_wrap & v_wrap;
    frame_count_d = frame_start_d ? frame_count_q + FRAME_W'(1) : frame_count_q;

    // Flags decode the next position so they land in the same register
    // stage as the counters. Compare in int so boundaries equal to
    // 2**COUNT_W (empty trailing regions) cannot alias.
    hx = int'(hpos_d);
    vy = int'(vpos_d);

    hblank_d   = (hx >= H_VISIBLE);
    vblank_d   = (vy >= V_VISIBLE);
    visible_d  = ~hblank_d & ~vblank_d;
    border_d   = ((hx < H_BLANK_START) | (hx >= H_BORDER_L)) &
                 ((vy < V_BLANK_START) | (vy >= V_BORDER_T)) & ~visible_d;

    h_sync_act = (hx >= H_SYNC_START) && (hx < H_SYNC_END);
    v_sync_act = (vy >= V_SYNC_START) && (vy < V_SYNC_END);
    hsync_d    = H_SYNC_POL ? h_sync_act : ~h_sync_act;
    vsync_d    = V_SYNC_POL ? v_sync_act : ~v_sync_act;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      frame_count_q <= '1;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      visible_q     <= 1'b0;
      border_q      <= BORDER_RST;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_count_q <= frame_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      visible_q     <= visible_d;
      border_q      <= border_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.o_hpos        = hpos_q;
  assign vid.o_vpos        = vpos_q;
  assign vid.o_hsync       = hsync_q;
  assign vid.o_vsync       = vsync_q;
  assign vid.o_hblank      = hblank_q;
  assign vid.o_vblank      = vblank_q;
  assign vid.o_visible     = visible_q;
  assign vid.o_border      = border_q;
  assign vid.o_line_start  = line_start_q;
  assign vid.o_frame_start = frame_start_q;
  assign vid.o_frame_count = frame_count_q;

endmodule

// File: tb/tb_video_timing_generator.sv
// Purpose : directed self-checking bench for video_timing_generator (default 800x525 and a 14x14 active-high build).
// Latency : outputs sampled 1 time unit after each rising clock edge.
// Backpressure: none; the bench paces the raster through i_ce.
module tb_video_timing_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, ce0, rst1_n, ce1;
  int   n_pass  = 0;
  int   n_total = 0;

  // Scratch statistics shared by the directed steps.
  int pos_err, hs_low, hs_first, hs_last, hb_first;
  int bd_cnt, bd_first, bd_last, vis_cnt, ls_cnt, ls_wide, ls_k0, ls_k1;
  int exp_h, exp_v, hs_err, vs_cnt, vs_first, vb_first, fs_cnt, h, v;
  logic prev_ls;

  video_timing_generator_if #(.COUNT_W(10), .FRAME_W(8)) vif0 ();
  video_timing_generator_if #(.COUNT_W(4),  .FRAME_W(4)) vif1 ();

  video_timing_generator dut0 (
    .i_clk   (clk),
    .i_rst_n (rst0_n),
    .i_ce    (ce0),
    .vid     (vif0)
  );

  video_timing_generator #(
    .H_VISIBLE(8), .H_RIGHT_BORDER(1), .H_FRONT_PORCH(1), .H_SYNC_TIME(2),
    .H_BACK_PORCH(1), .H_LEFT_BORDER(1),
    .V_VISIBLE(8), .V_BOTTOM_BORDER(1), .V_FRONT_PORCH(1), .V_SYNC_TIME(2),
    .V_BACK_PORCH(1), .V_TOP_BORDER(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .COUNT_W(4), .FRAME_W(4)
  ) dut1 (
    .i_clk   (clk),
    .i_rst_n (rst1_n),
    .i_ce    (ce1),
    .vid     (vif1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    rst0_n = 1'b0; ce0 = 1'b1;
    rst1_n = 1'b0; ce1 = 1'b1;
    repeat (3) tick();

    // Reset state, default timing
    chk("rst_hpos",   int'(vif0.o_hpos), 799);
    chk("rst_vpos",   int'(vif0.o_vpos), 524);
    chk("rst_hsync",  int'(vif0.o_hsync), 1);
    chk("rst_vsync",  int'(vif0.o_vsync), 1);
    chk("rst_vis",    int'(vif0.o_visible), 0);
    chk("rst_hblank", int'(vif0.o_hblank), 1);
    chk("rst_vblank", int'(vif0.o_vblank), 1);
    chk("rst_border", int'(vif0.o_border), 1);
    chk("rst_ls",     int'(vif0.o_line_start), 0);
    chk("rst_fs",     int'(vif0.o_frame_start), 0);
    chk("rst_fc",     int'(vif0.o_frame_count), 255);
    // Reset state, small active-high timing
    chk("s_rst_hpos",  int'(vif1.o_hpos), 13);
    chk("s_rst_vpos",  int'(vif1.o_vpos), 13);
    chk("s_rst_hsync", int'(vif1.o_hsync), 0);
    chk("s_rst_vsync", int'(vif1.o_vsync), 0);
    chk("s_rst_fc",    int'(vif1.o_frame_count), 15);
    chk("s_rst_bd",    int'(vif1.o_border), 1);

    // First pixel after release
    rst0_n = 1'b1;
    tick();
    chk("first_hpos",  int'(vif0.o_hpos), 0);
    chk("first_vpos",  int'(vif0.o_vpos), 0);
    chk("first_vis",   int'(vif0.o_visible), 1);
    chk("first_hblank",int'(vif0.o_hblank), 0);
    chk("first_border",int'(vif0.o_border), 0);
    chk("first_hsync", int'(vif0.o_hsync), 1);
    chk("first_ls",    int'(vif0.o_line_start), 1);
    chk("first_fs",    int'(vif0.o_frame_start), 1);
    chk("first_fc",    int'(vif0.o_frame_count), 0);
    chk("s_rst_prio_hpos", int'(vif1.o_hpos), 13);

    // One full line with i_ce high
    pos_err = 0; hs_low = 0; hs_first = -1; hs_last = -1; hb_first = -1;
    bd_cnt = 0; bd_first = -1; bd_last = -1; vis_cnt = 0; ls_cnt = 0;
    for (int i = 1; i < 800; i++) begin
      tick();
      if (int'(vif0.o_hpos) != i || int'(vif0.o_vpos) != 0) pos_err++;
      if (!vif0.o_hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (vif0.o_hblank && hb_first < 0) hb_first = i;
      if (vif0.o_border) begin
        bd_cnt++;
        if (bd_first < 0) bd_first = i;
        bd_last = i;
      end
      if (vif0.o_visible) vis_cnt++;
      ls_cnt += int'(vif0.o_line_start);
    end
    chk("line_pos_err",  pos_err, 0);
    chk("hsync_low_cnt", hs_low, 96);
    chk("hsync_first",   hs_first, 656);
    chk("hsync_last",    hs_last, 751);
    chk("hblank_rise",   hb_first, 640);
    chk("border_cnt",    bd_cnt, 16);
    chk("border_first",  bd_first, 640);
    chk("border_last",   bd_last, 799);
    chk("visible_cnt",   vis_cnt, 639);
    chk("ls_inside_line",ls_cnt, 0);
    tick();
    chk("wrap_hpos", int'(vif0.o_hpos), 0);
    chk("wrap_vpos", int'(vif0.o_vpos), 1);
    chk("wrap_ls",   int'(vif0.o_line_start), 1);
    chk("wrap_fs",   int'(vif0.o_frame_start), 0);

    // i_ce one clock in four over two lines
    exp_h = 0; exp_v = 1; pos_err = 0; ls_cnt = 0; ls_wide = 0;
    ls_k0 = -1; ls_k1 = -1; prev_ls = 1'b1;
    for (int k = 0; k < 6404; k++) begin
      ce0 = (k % 4 == 0);
      tick();
      if (ce0) begin
        if (exp_h == 799) begin
          exp_h = 0;
          exp_v++;
        end else begin
          exp_h++;
        end
      end
      if (int'(vif0.o_hpos) != exp_h || int'(vif0.o_vpos) != exp_v) pos_err++;
      if (vif0.o_line_start) begin
        ls_cnt++;
        if (prev_ls) ls_wide++;
        if (ls_k0 < 0) ls_k0 = k;
        else ls_k1 = k;
      end
      prev_ls = vif0.o_line_start;
    end
    chk("ce4_pos_err",  pos_err, 0);
    chk("ce4_ls_cnt",   ls_cnt, 2);
    chk("ce4_ls_wide",  ls_wide, 0);
    chk("ce4_ls_first", ls_k0, 3196);
    chk("ce4_period",   ls_k1 - ls_k0, 3200);
    chk("ce4_end_hpos", int'(vif0.o_hpos), 1);
    chk("ce4_end_vpos", int'(vif0.o_vpos), 3);

    // Reset mid-frame, then clean restart
    ce0 = 1'b1; rst0_n = 1'b0;
    tick();
    chk("mid_rst_hpos", int'(vif0.o_hpos), 799);
    chk("mid_rst_vpos", int'(vif0.o_vpos), 524);
    chk("mid_rst_fc",   int'(vif0.o_frame_count), 255);
    chk("mid_rst_fs",   int'(vif0.o_frame_start), 0);
    rst0_n = 1'b1;
    tick();
    chk("restart_hpos", int'(vif0.o_hpos), 0);
    chk("restart_vpos", int'(vif0.o_vpos), 0);
    chk("restart_fs",   int'(vif0.o_frame_start), 1);
    chk("restart_fc",   int'(vif0.o_frame_count), 0);
    ce0 = 1'b0;
    tick();
    chk("ce0_fs_clear", int'(vif0.o_frame_start), 0);
    chk("ce0_ls_clear", int'(vif0.o_line_start), 0);
    chk("ce0_hold_hpos",int'(vif0.o_hpos), 0);
    chk("ce0_hold_vis", int'(vif0.o_visible), 1);

    // Small active-high timing: full frame
    rst1_n = 1'b1;
    tick();
    chk("s_first_hpos", int'(vif1.o_hpos), 0);
    chk("s_first_fs",   int'(vif1.o_frame_start), 1);
    chk("s_first_fc",   int'(vif1.o_frame_count), 0);
    pos_err = 0; hs_err = 0; vs_cnt = 0; vs_first = -1; vb_first = -1; fs_cnt = 0;
    for (int i = 1; i < 196; i++) begin
      tick();
      h = i % 14;
      v = i / 14;
      if (int'(vif1.o_hpos) != h || int'(vif1.o_vpos) != v) pos_err++;
      hs_err += int'(vif1.o_hsync != ((h == 10) || (h == 11)));
      if (vif1.o_vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = i;
      end
      if (vif1.o_vblank && vb_first < 0) vb_first = i;
      fs_cnt += int'(vif1.o_frame_start);
    end
    chk("s_pos_err",   pos_err, 0);
    chk("s_hsync_err", hs_err, 0);
    chk("s_vsync_cnt", vs_cnt, 28);
    chk("s_vsync_first", vs_first, 140);
    chk("s_vblank_first", vb_first, 112);
    chk("s_fs_inside", fs_cnt, 0);
    tick();
    chk("s_frame_hpos", int'(vif1.o_hpos), 0);
    chk("s_frame_vpos", int'(vif1.o_vpos), 0);
    chk("s_frame_fs",   int'(vif1.o_frame_start), 1);
    chk("s_frame_fc",   int'(vif1.o_frame_count), 1);

    // Frame counter up to its top value and through the wrap
    repeat (14 * 196) tick();
    chk("s_fc_top_fs", int'(vif1.o_frame_start), 1);
    chk("s_fc_top",    int'(vif1.o_frame_count), 15);
    repeat (196) tick();
    chk("s_fc_wrap_fs", int'(vif1.o_frame_start), 1);
    chk("s_fc_wrap",    int'(vif1.o_frame_count), 0);

    // Mid-frame reset at (5,7) with i_ce held high
    repeat (7 * 14 + 5) tick();
    chk("s_pre_hpos", int'(vif1.o_hpos), 5);
    chk("s_pre_vpos", int'(vif1.o_vpos), 7);
    rst1_n = 1'b0;
    tick();
    chk("s_mid_hpos", int'(vif1.o_hpos), 13);
    chk("s_mid_vpos", int'(vif1.o_vpos), 13);
    chk("s_mid_fc",   int'(vif1.o_frame_count), 15);
    chk("s_mid_hsync",int'(vif1.o_hsync), 0);
    tick();
    chk("s_mid_hold_hpos", int'(vif1.o_hpos), 13);
    rst1_n = 1'b1;
    tick();
    chk("s_re_hpos", int'(vif1.o_hpos), 0);
    chk("s_re_vpos", int'(vif1.o_vpos), 0);
    chk("s_re_fs",   int'(vif1.o_frame_start), 1);
    chk("s_re_fc",   int'(vif1.o_frame_count), 0);
    chk("s_re_vis",  int'(vif1.o_visible), 1);
    tick();
    chk("s_next_hpos", int'(vif1.o_hpos), 1);
    chk("s_next_fs",   int'(vif1.o_frame_start), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/video_timing_generator.md
# video_timing_generator

Parametrised raster timing generator for the VGA output path. It produces horizontal and vertical sync, blanking, visible-area and border flags, pixel and line positions, line-start and frame-start strobes, and a frame counter. All outputs are registered and describe the same pixel. Timing advances only on a pixel clock-enable, so the block runs from the system clock at any integer pixel divide. It drives the pixel pipeline and the VGA pins, and its strobes sequence frame-synchronous logic such as framebuffer address reset and palette swaps.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_RIGHT_BORDER, 8, right border pixels
- H_FRONT_PORCH, 8, horizontal front porch
- H_SYNC_TIME, 96, hsync width in pixels
- H_BACK_PORCH, 40, horizontal back porch
- H_LEFT_BORDER, 8, left border pixels
- V_VISIBLE, 480; V_BOTTOM_BORDER, 8; V_FRONT_PORCH, 2; V_SYNC_TIME, 2; V_BACK_PORCH, 25; V_TOP_BORDER, 8; vertical equivalents in lines
- H_SYNC_POL, 0, hsync active level: 0 = active-low, 1 = active-high
- V_SYNC_POL, 0, vsync active level, same encoding as H_SYNC_POL
- COUNT_W, 10, position counter width; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 8, frame counter width
- i_clk  in  1  system/pixel clock
- i_rst_n  in  1  reset: synchronous, active-low
- i_ce  in  1  pixel clock-enable; the raster advances one pixel per clock where i_ce=1
- o_hpos, o_vpos  out  COUNT_W  current pixel column and line
- o_hsync, o_vsync  out  1  sync outputs at the parameterised polarity
- o_hblank, o_vblank  out  1  high outside the visible columns / visible lines
- o_visible  out  1  high when the pixel is in the visible area in both axes
- o_border  out  1  high when the pixel is in the border ring and not visible
- o_line_start  out  1  one-clock strobe when o_hpos becomes 0
- o_frame_start  out  1  one-clock strobe when (o_hpos, o_vpos) becomes (0, 0)
- o_frame_count  out  FRAME_W  number of frames started, modulo 2^FRAME_W

## Operation
- Derived horizontal boundaries:
  - H_BLANK_START = H_VISIBLE + H_RIGHT_BORDER
  - H_SYNC_START = H_BLANK_START + H_FRONT_PORCH
  - H_SYNC_END = H_SYNC_START + H_SYNC_TIME
  - H_BORDER_L = H_SYNC_END + H_BACK_PORCH
  - H_TOTAL = H_BORDER_L + H_LEFT_BORDER
  - Vertical boundaries are derived the same way. Defaults give H_TOTAL=800 and V_TOTAL=525.
- Counters:
  - hpos increments on each i_ce and wraps from H_TOTAL-1 to 0.
  - vpos increments only when hpos wraps, and itself wraps from V_TOTAL-1 to 0.
- Flags are decoded from the next counter value and registered on the same edge as the counters, so every output is aligned with o_hpos/o_vpos.
  - hsync is active when H_SYNC_START ≤ hpos < H_SYNC_END.
  - vsync is active when V_SYNC_START ≤ vpos < V_SYNC_END, across whole lines (vsync changes only together with hpos=0).
  - o_hblank = hpos ≥ H_VISIBLE; o_vblank = vpos ≥ V_VISIBLE; o_visible = ~o_hblank & ~o_vblank.
  - o_border = (hpos < H_BLANK_START | hpos ≥ H_BORDER_L) & (vpos < V_BLANK_START | vpos ≥ V_BORDER_T) & ~o_visible.
  - Output level is the active level while the sync condition holds, otherwise its inverse.
- Strobes:
  - o_line_start and o_frame_start go high on the clock at which the counters load hpos=0 (and vpos=0 for o_frame_start).
  - They clear on the next clock even if i_ce is low, so each is exactly one i_clk cycle wide.
- o_frame_count increments on the same edge that asserts o_frame_start and wraps at 2^FRAME_W.
- With i_ce=0, all registers hold except the strobes, which clear.

## Timing
- Reset (i_rst_n=0 at a clock edge) loads:
  - hpos=H_TOTAL-1, vpos=V_TOTAL-1, o_frame_count = all ones
  - o_hblank=o_vblank=1, o_visible=0, o_border=1 (if H_LEFT_BORDER>0 and V_TOP_BORDER>0, else 0)
  - both syncs at their inactive level, strobes 0
- Reset has priority over i_ce, and reset asserted mid-frame takes effect at the next clock edge.
- After reset release, the first clock with i_ce=1 produces:
  - (0,0), o_visible=1, o_line_start=o_frame_start=1, o_frame_count=0
- Latency from a counter value to its flags is zero: all outputs are registered together.
- Line length is H_TOTAL i_ce pulses; frame length is H_TOTAL·V_TOTAL i_ce pulses; with i_ce tied high this is 420000 clocks at the defaults.
- Simultaneous events: at the last pixel of a frame, the hpos wrap, vpos wrap, both strobes and the frame count increment all occur on one edge.

## Test plan
- Reset with i_ce=1 held for 3 clocks, then release:
  - during reset: (799,524), syncs inactive (high), visible=0, strobes 0
  - next clock: (0,0), frame_start=1, frame_count=0
- Run one full line with i_ce=1:
  - o_hsync low exactly for hpos 656..751 (96 clocks)
  - o_hblank rises at hpos 640
  - o_border high at hpos 640..647 and 792..799 on a visible line
  - line_start period is 800 clocks
- Run one full frame:
  - o_vsync low for lines 490–491 (1600 clocks), starting at hpos=0
  - o_vblank high from line 480
  - frame_start period is 420000 clocks; frame_count steps by 1 per frame and wraps 255→0
- Drive i_ce high one clock in four:
  - positions advance every 4th clock
  - strobes are 1 clock wide
  - line period is 3200 clocks
- Set H_SYNC_POL=1 and V_SYNC_POL=1 with small timing (for example 8/1/1/2/1/1 per axis):
  - syncs active-high at the derived positions
  - totals are 14 in each axis
- Assert reset at (300,200) mid-frame: counters load (799,524) on the same edge, and the frame restarts cleanly.
